// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus: request/address out of the fetch unit,
// acknowledge/data back from the memory.
interface instr_fetch_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   req;
  logic [PC_WIDTH-1:0]    addr;
  logic                   ack;
  logic [INSTR_WIDTH-1:0] rdata;

  // Fetch-unit side
  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  // Memory side
  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the program from START_ADDR to LAST_ADDR,
// fetching each word over a req/ack bus, holding it in an instruction
// register and presenting its decoded fields until downstream accepts it.
module instr_fetch #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int START_ADDR  = 0,
  parameter int LAST_ADDR   = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  instr_fetch_if.master       imem,
  output logic [2:0]          opcode,
  output logic [2:0]          rd,
  output logic [2:0]          rs,
  output logic [2:0]          rt,
  output logic [3:0]          shamt,
  output logic                issue_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted
);

  localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(START_ADDR);
  localparam logic [PC_WIDTH-1:0] LAST_PC  = PC_WIDTH'(LAST_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t                 state_reg;
  logic [PC_WIDTH-1:0]    pc_reg;
  logic [INSTR_WIDTH-1:0] ir_reg;

  // Sequencer: program counter, instruction register and state advance together.
  // Reset is asynchronous so an outstanding request is abandoned immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= START_PC;
      ir_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            pc_reg    <= START_PC;
            state_reg <= FETCH;
          end
        end
        FETCH: begin
          // Address is held on pc_reg; wait as long as the memory needs.
          if (imem.ack) begin
            ir_reg    <= imem.rdata;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            if (pc_reg == LAST_PC) begin
              state_reg <= HALT;
            end else begin
              // Natural modulo wrap of the counter width lets a program
              // run through address 0 when LAST_ADDR < START_ADDR.
              pc_reg    <= pc_reg + 1'b1;
              state_reg <= FETCH;
            end
          end
        end
        HALT: begin
          // IR is kept so the fields still show the last instruction.
          if (start) begin
            pc_reg    <= START_PC;
            state_reg <= FETCH;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs come straight from registers or a decode of the state register,
  // so no input reaches an output combinationally.
  assign imem.req    = (state_reg == FETCH);
  assign imem.addr   = pc_reg;
  assign issue_valid = (state_reg == ISSUE);
  assign busy        = (state_reg == FETCH) || (state_reg == ISSUE);
  assign halted      = (state_reg == HALT);
  assign pc          = pc_reg;

  // Fixed 16-bit instruction layout: opcode | rd | rs | rt | shamt.
  assign opcode = ir_reg[15:13];
  assign rd     = ir_reg[12:10];
  assign rs     = ir_reg[9:7];
  assign rt     = ir_reg[6:4];
  assign shamt  = ir_reg[3:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: three configurations (short program,
// 3-bit wrapping counter, single-instruction program) driven with random
// memory contents, ack delays, stalls and noise, checked against a model
// that simply lists the addresses a program should visit.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stall;
  logic        ack;
  logic [15:0] rdata;

  int sel;
  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [256];

  int cfg_w     [3] = '{8, 3, 4};
  int cfg_start [3] = '{0, 6, 9};
  int cfg_last  [3] = '{1, 1, 9};

  always #5 clk = ~clk;

  // ---------------- DUT A: PC_WIDTH=8, START=0, LAST=1 ----------------
  instr_fetch_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus_a ();
  logic       start_a;
  logic [2:0] op_a, rd_a, rs_a, rt_a;
  logic [3:0] sh_a;
  logic       v_a, busy_a, halt_a;
  logic [7:0] pc_a;
  assign start_a     = start && (sel == 0);
  assign bus_a.ack   = ack;
  assign bus_a.rdata = rdata;
  instr_fetch #(.PC_WIDTH(8), .INSTR_WIDTH(16), .START_ADDR(0), .LAST_ADDR(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .stall(stall), .imem(bus_a),
    .opcode(op_a), .rd(rd_a), .rs(rs_a), .rt(rt_a), .shamt(sh_a),
    .issue_valid(v_a), .pc(pc_a), .busy(busy_a), .halted(halt_a));

  // ---------------- DUT B: PC_WIDTH=3, START=6, LAST=1 ----------------
  instr_fetch_if #(.PC_WIDTH(3), .INSTR_WIDTH(16)) bus_b ();
  logic       start_b;
  logic [2:0] op_b, rd_b, rs_b, rt_b;
  logic [3:0] sh_b;
  logic       v_b, busy_b, halt_b;
  logic [2:0] pc_b;
  assign start_b     = start && (sel == 1);
  assign bus_b.ack   = ack;
  assign bus_b.rdata = rdata;
  instr_fetch #(.PC_WIDTH(3), .INSTR_WIDTH(16), .START_ADDR(6), .LAST_ADDR(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stall(stall), .imem(bus_b),
    .opcode(op_b), .rd(rd_b), .rs(rs_b), .rt(rt_b), .shamt(sh_b),
    .issue_valid(v_b), .pc(pc_b), .busy(busy_b), .halted(halt_b));

  // ---------------- DUT C: PC_WIDTH=4, START=LAST=9 ----------------
  instr_fetch_if #(.PC_WIDTH(4), .INSTR_WIDTH(16)) bus_c ();
  logic       start_c;
  logic [2:0] op_c, rd_c, rs_c, rt_c;
  logic [3:0] sh_c;
  logic       v_c, busy_c, halt_c;
  logic [3:0] pc_c;
  assign start_c     = start && (sel == 2);
  assign bus_c.ack   = ack;
  assign bus_c.rdata = rdata;
  instr_fetch #(.PC_WIDTH(4), .INSTR_WIDTH(16), .START_ADDR(9), .LAST_ADDR(9)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .stall(stall), .imem(bus_c),
    .opcode(op_c), .rd(rd_c), .rs(rs_c), .rt(rt_c), .shamt(sh_c),
    .issue_valid(v_c), .pc(pc_c), .busy(busy_c), .halted(halt_c));

  // Observation mux onto the selected DUT
  logic       o_req, o_valid, o_busy, o_halted;
  logic [7:0] o_addr, o_pc;
  logic [2:0] o_op, o_rd, o_rs, o_rt;
  logic [3:0] o_sh;
  always_comb begin
    o_req = bus_a.req; o_addr = bus_a.addr; o_valid = v_a; o_busy = busy_a;
    o_halted = halt_a; o_pc = pc_a;
    o_op = op_a; o_rd = rd_a; o_rs = rs_a; o_rt = rt_a; o_sh = sh_a;
    if (sel == 1) begin
      o_req = bus_b.req; o_addr = {5'b0, bus_b.addr}; o_valid = v_b; o_busy = busy_b;
      o_halted = halt_b; o_pc = {5'b0, pc_b};
      o_op = op_b; o_rd = rd_b; o_rs = rs_b; o_rt = rt_b; o_sh = sh_b;
    end else if (sel == 2) begin
      o_req = bus_c.req; o_addr = {4'b0, bus_c.addr}; o_valid = v_c; o_busy = busy_c;
      o_halted = halt_c; o_pc = {4'b0, pc_c};
      o_op = op_c; o_rd = rd_c; o_rs = rs_c; o_rt = rt_c; o_sh = sh_c;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, sel, obs, expv);
    end
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
  endtask

  // Field checks against a plain bit-slice of the expected word
  task automatic chk_fields(input string tag, input logic [15:0] w);
    chk({tag, "_opcode"}, 32'(o_op), 32'(w >> 13));
    chk({tag, "_rd"},     32'(o_rd), 32'((w >> 10) & 16'h7));
    chk({tag, "_rs"},     32'(o_rs), 32'((w >> 7) & 16'h7));
    chk({tag, "_rt"},     32'(o_rt), 32'((w >> 4) & 16'h7));
    chk({tag, "_shamt"},  32'(o_sh), 32'(w & 16'hF));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"},    32'(o_req), 0);
    chk({tag, "_valid"},  32'(o_valid), 0);
    chk({tag, "_busy"},   32'(o_busy), 0);
    chk({tag, "_halted"}, 32'(o_halted), 0);
    chk({tag, "_pc"},     32'(o_pc), 32'(cfg_start[sel]));
    chk({tag, "_addr"},   32'(o_addr), 32'(cfg_start[sel]));
    chk({tag, "_fields"}, 32'({o_op, o_rd, o_rs, o_rt, o_sh}), 0);
  endtask

  // Run one program from start pulse to HALT.  The model is just the list of
  // addresses the program visits; each issue must show mem[] at that address.
  task automatic run_prog(input int dmin, input int dmax, input int stall_pct, input bit noise);
    int   exp_q[$];
    int   a, wait_cnt, target, budget, n_issued;
    bit   acked, issued;
    logic [15:0] w;
    a = cfg_start[sel];
    forever begin
      exp_q.push_back(a);
      if (a == cfg_last[sel]) break;
      a = (a + 1) % (1 << cfg_w[sel]);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    acked = 0; issued = 0; wait_cnt = 0; n_issued = 0;
    target = $urandom_range(dmax, dmin);
    for (budget = 0; budget < 600; budget++) begin
      ack = 1'b0; stall = 1'b0; start = 1'b0; rdata = 16'($urandom);
      if (acked) begin
        chk("ack_to_issue", 32'(o_valid), 1);
        chk("req_drops_after_ack", 32'(o_req), 0);
      end
      if (issued) chk("after_issue", 32'(exp_q.size() == 0 ? o_halted : o_req), 1);
      acked = 0; issued = 0;
      if (o_halted) begin
        chk("halt_all_issued", 32'(exp_q.size()), 0);
        chk("halt_busy", 32'(o_busy), 0);
        chk("halt_valid", 32'(o_valid), 0);
        break;
      end
      if (o_req) begin
        chk("fetch_addr", 32'(o_addr), 32'(exp_q[0]));
        chk("fetch_valid", 32'(o_valid), 0);
        chk("fetch_busy", 32'(o_busy), 1);
        if (wait_cnt >= target) begin
          ack = 1'b1; rdata = mem[exp_q[0]]; acked = 1;
          wait_cnt = 0; target = $urandom_range(dmax, dmin);
        end else begin
          wait_cnt++;
        end
        if (noise && $urandom_range(3, 0) == 0) start = 1'b1;
      end else if (o_valid) begin
        w = mem[exp_q[0]];
        chk_fields("issue", w);
        chk("issue_pc", 32'(o_pc), 32'(exp_q[0]));
        chk("issue_busy", 32'(o_busy), 1);
        if ($urandom_range(99, 0) < stall_pct) begin
          stall = 1'b1;
        end else begin
          issued = 1; n_issued++;
          void'(exp_q.pop_front());
        end
        if (noise && $urandom_range(2, 0) == 0) start = 1'b1;
        if (noise && $urandom_range(2, 0) == 0) ack = 1'b1;
      end else begin
        chk("unexpected_idle", 32'(o_busy), 1);
      end
      tick();
    end
    ack = 1'b0; stall = 1'b0; start = 1'b0;
    chk("program_completed", 32'(o_halted), 1);
    $display("[TB] dut=%0d program done: %0d issues, %0d cycles", sel, n_issued, budget);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; ack = 1'b0; rdata = '0; sel = 0;
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk_reset_state("reset");
    end
    sel = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_reset_state("idle");

    // Directed words, ack in request cycle, no stall
    randomize_mem();
    mem[0] = 16'h2A31;
    mem[1] = 16'hC085;
    run_prog(0, 0, 0, 1'b0);
    chk("final_pc", 32'(o_pc), 1);
    chk("final_opcode", 32'(o_op), 6);
    chk("final_shamt", 32'(o_sh), 5);

    // Fixed three-cycle ack delay
    randomize_mem();
    run_prog(3, 3, 0, 1'b0);

    // Random delays and stalls, restarting from HALT each time, with noise
    for (int r = 0; r < 6; r++) begin
      randomize_mem();
      run_prog(0, 3, 60, r[0]);
    end

    // Async reset between edges during FETCH
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("pre_reset_req", 32'(o_req), 1);
    #2 reset = 1'b1;
    #1 chk_reset_state("reset_in_fetch");
    reset = 1'b0;
    tick();
    chk("idle_after_reset", 32'(o_busy), 0);
    // Spurious ack while idle must not load IR
    ack = 1'b1; rdata = 16'hFFFF;
    tick();
    ack = 1'b0;
    chk("idle_spurious_ack_fields", 32'({o_op, o_rd, o_rs, o_rt, o_sh}), 0);
    chk("idle_spurious_ack_busy", 32'(o_busy), 0);
    randomize_mem();
    run_prog(0, 2, 30, 1'b1);

    // Async reset during a stalled ISSUE
    start = 1'b1; tick(); start = 1'b0;
    ack = 1'b1; rdata = 16'hB6D7;
    tick();
    ack = 1'b0; stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(o_valid), 1);
      chk_fields("stall", 16'hB6D7);
      chk("stall_pc", 32'(o_pc), 0);
      tick();
    end
    #2 reset = 1'b1;
    #1 chk_reset_state("reset_in_issue");
    reset = 1'b0; stall = 1'b0;
    tick();
    chk("no_partial_issue", 32'(o_busy), 0);

    // Wrapping 3-bit counter: 6,7,0,1
    sel = 1;
    for (int r = 0; r < 4; r++) begin
      randomize_mem();
      run_prog(0, 2, 50, r[0]);
    end

    // Single-instruction program
    sel = 2;
    for (int r = 0; r < 3; r++) begin
      randomize_mem();
      run_prog(0, 2, 50, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
